desc_norm_sched: RTL
====================

Name: desc_norm_sched

Overview:
- Sequences L2 normalisation of one descriptor at a time ahead of the int8 normaliser (8 lanes × int8 × 24-bit reciprocal, round/saturate).
- Buffers one full descriptor (BEATS × 64-bit, 8 signed int8 per beat) and accumulates its sum of squares.
- Hands the sum to an external reciprocal-square-root unit, captures the returned 24-bit factor, then replays the buffered beats to the normaliser with the factor held constant.

Parameters:
- BEATS, 32, beats per descriptor (256 int8 / 8).
- SUMW, 24, sum-of-squares width (max 256·128² = 2^22 fits).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_axis_desc_tdata  in  64  raw descriptor beat; byte k = lane k, signed
- s_axis_desc_tvalid  in  1  input valid
- s_axis_desc_tlast  in  1  marks final beat of the descriptor
- s_axis_desc_tready  out  1  input ready
- rsqrt_req_valid  out  1  sum-of-squares request valid
- rsqrt_req_data  out  SUMW  sum of squares
- rsqrt_req_ready  in  1  rsqrt unit accepts request
- rsqrt_resp_valid  in  1  one-cycle pulse, factor valid
- rsqrt_resp_data  in  24  reciprocal sqrt, same fixed-point format the normaliser consumes
- reciprocal_squa_root  out  24  factor driven to the normaliser B input
- m_axis_raw_tdata  out  64  replayed beat to the normaliser
- m_axis_raw_tvalid  out  1  replay valid
- m_axis_raw_tlast  out  1  final replayed beat
- m_axis_raw_tready  in  1  normaliser ready
- busy  out  1  state != IDLE
- len_err  out  1  sticky tlast/length mismatch flag
- desc_done  out  1  one-cycle pulse when the last replay beat is accepted

Behaviour:
- Reset values (rstn=0 at a clk edge): state=IDLE; all pointers=0; sum=0; reciprocal_squa_root=0; every valid/ready/pulse output=0; len_err=0. Reset mid-operation discards the buffered descriptor and any outstanding rsqrt request. No response is expected after reset; a stray rsqrt_resp_valid in any state other than WAIT is ignored.
- States: IDLE, LOAD, REQ, WAIT, PLAY.
- IDLE: s_axis_desc_tready=1. The first accepted beat is written to buf[0], its squares are added to a zeroed sum, wr_ptr=1, and the state goes to LOAD. If BEATS=1, the state goes straight to the post-load transition.
- LOAD:
  - s_axis_desc_tready=1.
  - Each accepted beat (valid&ready) is written to buf[wr_ptr], and sum += Σ_{k=0..7} (signed byte k)².
  - Each square is unsigned 15-bit; (-128)² = 16384. Sums are unsigned in SUMW bits, with no saturation needed.
  - The load ends on the BEATS-th accepted beat. Length is counted, not taken from tlast.
  - tlast on a beat other than BEATS-1, or no tlast on beat BEATS-1, sets len_err (sticky until reset). Processing continues by count.
- Post-load transition (cycle after final beat): if sum==0, reciprocal_squa_root←0 and go to PLAY, skipping REQ/WAIT. Otherwise go to REQ.
- REQ: rsqrt_req_valid=1 and rsqrt_req_data=sum, both stable until rsqrt_req_ready is high at a clk edge, then go to WAIT. s_axis_desc_tready=0 from here until the state returns to IDLE.
- WAIT: on rsqrt_resp_valid, reciprocal_squa_root←rsqrt_resp_data, rd_ptr=0, go to PLAY.
- PLAY:
  - m_axis_raw_tvalid=1, m_axis_raw_tdata=buf[rd_ptr], m_axis_raw_tlast=(rd_ptr==BEATS-1).
  - rd_ptr advances on valid&ready. Data/last stay stable while ready=0 (AXI-stream rules).
  - When the last beat is accepted: desc_done pulses and the state goes to IDLE.
- reciprocal_squa_root changes only on WAIT capture or the zero-sum path. It is held through all of PLAY and beyond, so the normaliser's one-stage register sees a constant factor for every beat, including the final in-flight one.
- Latency: final input beat accepted at edge N → rsqrt_req_valid high after edge N+1. Response captured at edge M → first m_axis_raw_tvalid after edge M. Minimum replay = BEATS cycles with ready held high.
- No overlap: the next descriptor is accepted only in IDLE, i.e. from the cycle after desc_done.
- Buffer: BEATS×64 register array with combinational read. rd_ptr/wr_ptr are $clog2(BEATS) bits and wrap to 0 after BEATS-1.

Test Plan:
- Nominal: 32 beats of all bytes 0x01, tlast on beat 31 → rsqrt_req_data=256; respond 0x000800 → 32 replayed beats identical to input, reciprocal_squa_root=0x000800 throughout, desc_done once, len_err=0.
- Extreme: all bytes 0x80 → rsqrt_req_data=4194304 (0x400000), no overflow; mix of 0x7F/0x81 lanes gives 16129 per lane.
- Zero descriptor: all bytes 0 → no rsqrt_req_valid ever, reciprocal_squa_root=0, 32 zero beats replayed.
- Backpressure: rsqrt_req_ready low 5 cycles (request held stable), then random m_axis_raw_tready → exact beat order preserved, tdata/tlast stable while stalled, s_axis_desc_tready=0 until IDLE.
- Length error: tlast on beat 15 → len_err=1, load continues to 32 beats, normal replay; len_err stays 1 for the next clean descriptor.
- Reset mid-PLAY at beat 10 → all outputs return to reset values next cycle; a fresh descriptor then processes correctly, and a late rsqrt_resp_valid pulse in IDLE is ignored.

Source files
------------

// File: rtl/desc_norm_sched.sv
// desc_norm_sched: buffers one int8 descriptor, accumulates its sum of
// squares, obtains a reciprocal-sqrt factor from an external unit and
// replays the buffered beats to the int8 normaliser with the factor held.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a source keeps valid and data stable while ready is low.
// rsqrt_resp_valid is the one exception: a single-cycle pulse with no ready,
// honoured only while waiting for the factor.
module desc_norm_sched #(
  parameter int BEATS = 32,
  parameter int SUMW  = 24
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [63:0]     s_axis_desc_tdata,
  input  logic            s_axis_desc_tvalid,
  input  logic            s_axis_desc_tlast,
  output logic            s_axis_desc_tready,
  output logic            rsqrt_req_valid,
  output logic [SUMW-1:0] rsqrt_req_data,
  input  logic            rsqrt_req_ready,
  input  logic            rsqrt_resp_valid,
  input  logic [23:0]     rsqrt_resp_data,
  output logic [23:0]     reciprocal_squa_root,
  output logic [63:0]     m_axis_raw_tdata,
  output logic            m_axis_raw_tvalid,
  output logic            m_axis_raw_tlast,
  input  logic            m_axis_raw_tready,
  output logic            busy,
  output logic            len_err,
  output logic            desc_done,
  output logic [2:0]      dbg_state_o
);

  localparam int PW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    PLAY = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SUMW-1:0] sum_q, sum_d;
  logic [23:0]     factor_q, factor_d;
  logic            len_err_q, len_err_d;
  logic            tready_q, tready_d;
  logic [63:0]     buf_q [BEATS];

  logic            in_fire;
  logic            out_fire;
  logic            load_full;
  logic [PW-1:0]   wr_idx;
  logic [SUMW-1:0] beat_sq;

  // Sum of the eight signed byte squares of one beat; each square fits 15 bits.
  function automatic logic [SUMW-1:0] beat_sumsq(input logic [63:0] beat);
    logic [SUMW-1:0]    acc;
    logic signed [15:0] bx;
    logic [15:0]        sq;
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      bx  = {{8{beat[8*k+7]}}, beat[8*k +: 8]};
      sq  = bx * bx;
      acc = acc + SUMW'(sq);
    end
    return acc;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // A wrapped write pointer while in LOAD means every beat has arrived:
  // this is the single post-load decision cycle.
  assign load_full = (state_q == LOAD) && (wr_ptr_q == '0);
  assign in_fire   = s_axis_desc_tvalid && tready_q;
  assign out_fire  = (state_q == PLAY) && m_axis_raw_tready;
  assign wr_idx    = (state_q == IDLE) ? '0 : wr_ptr_q;
  assign beat_sq   = beat_sumsq(s_axis_desc_tdata);

  // Next-state and datapath updates for the descriptor sequencer.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    sum_d     = sum_q;
    factor_d  = factor_q;
    len_err_d = len_err_q;
    case (state_q)
      IDLE, LOAD: begin
        if (load_full) begin
          if (sum_q == '0) begin
            factor_d = '0;
            rd_ptr_d = '0;
            state_d  = PLAY;
          end else begin
            state_d = REQ;
          end
        end else if (in_fire) begin
          sum_d    = (state_q == IDLE) ? beat_sq : sum_q + beat_sq;
          wr_ptr_d = ptr_inc(wr_idx);
          state_d  = LOAD;
          if (s_axis_desc_tlast != (wr_idx == LAST_IDX)) len_err_d = 1'b1;
        end
      end
      REQ: begin
        if (rsqrt_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (rsqrt_resp_valid) begin
          factor_d = rsqrt_resp_data;
          rd_ptr_d = '0;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (out_fire) begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
          if (rd_ptr_q == LAST_IDX) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    tready_d = (state_d == IDLE) || ((state_d == LOAD) && (wr_ptr_d != '0));
  end

  // State, pointer, sum and factor registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      sum_q     <= '0;
      factor_q  <= '0;
      len_err_q <= 1'b0;
      tready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sum_q     <= sum_d;
      factor_q  <= factor_d;
      len_err_q <= len_err_d;
      tready_q  <= tready_d;
    end
  end

  // Descriptor buffer; contents need no reset since pointers gate every use.
  always_ff @(posedge clk) begin
    if (in_fire) buf_q[wr_idx] <= s_axis_desc_tdata;
  end

  assign s_axis_desc_tready   = tready_q;
  assign rsqrt_req_valid      = (state_q == REQ);
  assign rsqrt_req_data       = sum_q;
  assign reciprocal_squa_root = factor_q;
  assign m_axis_raw_tvalid    = (state_q == PLAY);
  assign m_axis_raw_tdata     = buf_q[rd_ptr_q];
  assign m_axis_raw_tlast     = (state_q == PLAY) && (rd_ptr_q == LAST_IDX);
  assign desc_done            = out_fire && (rd_ptr_q == LAST_IDX);
  assign busy                 = (state_q != IDLE);
  assign len_err              = len_err_q;
  assign dbg_state_o          = state_q;

endmodule
